// File: rtl/seg_adder_pkg.sv
// Shared types and elaboration helpers for the segmented adder/subtractor.
package seg_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of W-bit segments needed to cover an N-bit operand.
  function automatic int nseg(input int n, input int w);
    return n / w;
  endfunction

  // Segment counter width; a single-segment adder still keeps a 1-bit counter.
  function automatic int cntw(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/seg_adder_ripple.sv
// W-bit ripple-carry segment adder, reused by seg_adder once per clock.
module seg_ripple #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  // One full-adder stage per bit; the carry chain is W stages long.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[W];

endmodule

// File: rtl/seg_adder.sv
// Multi-cycle N-bit adder/subtractor that walks one W-bit segment per clock,
// least-significant segment first, with valid/ready on both sides.
module seg_adder
  import seg_adder_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int K  = nseg(N, W);
  localparam int CW = cntw(K);

  if ((W < 1) || (N % W != 0)) begin : g_bad_width
    $error("seg_adder: N must be a non-zero multiple of W");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_next;
  logic          carry;
  logic [W-1:0]  seg_s;
  logic          seg_co;
  logic          last;
  int            base;

  // Bit offset of the segment being processed this cycle.
  always_comb begin
    base = int'(cnt) * W;
  end

  seg_ripple #(.W(W)) u_seg (
    .x  (a_reg[base +: W]),
    .y  (b_reg[base +: W]),
    .ci (carry),
    .s  (seg_s),
    .co (seg_co)
  );

  // Accumulator as it will look once the current segment is written back.
  always_comb begin
    acc_next = acc;
    acc_next[base +: W] = seg_s;
  end

  assign last = (cnt == CW'(K - 1));

  // Handshake FSM: latch operands in IDLE, ripple one segment per RUN cycle,
  // and hold the registered result in DONE until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= sub ? ~b : b;
            carry    <= cin ^ sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= seg_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cnt       <= '0;
            sum       <= acc_next;
            cout      <= seg_co;
            ovf       <= (a_reg[N-1] == b_reg[N-1]) && (acc_next[N-1] != a_reg[N-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_adder.sv
// Directed and model-checked bench for seg_adder at N=64/W=16 and N=8/W=8.
module tb_seg_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic        ordy;
  logic        sel8;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;

  logic        rdy64, ov64, cout64, ovf64;
  logic [63:0] sum64;
  logic        rdy8, ov8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        rdy_m, ov_m, cout_m, ovf_m;
  logic [63:0] sum_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_adder #(.N(64), .W(16)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv & ~sel8),
    .in_ready  (rdy64),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (ov64),
    .out_ready (ordy & ~sel8),
    .sum       (sum64),
    .cout      (cout64),
    .ovf       (ovf64)
  );

  seg_adder #(.N(8), .W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv & sel8),
    .in_ready  (rdy8),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .cin       (cin),
    .sub       (sub),
    .out_valid (ov8),
    .out_ready (ordy & sel8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  // Present whichever instance is currently selected to the checking tasks.
  always_comb begin
    rdy_m  = sel8 ? rdy8  : rdy64;
    ov_m   = sel8 ? ov8   : ov64;
    cout_m = sel8 ? cout8 : cout64;
    ovf_m  = sel8 ? ovf8  : ovf64;
    sum_m  = sel8 ? {56'b0, sum8} : sum64;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on an n-bit operand pair.
  task automatic refModel(input int n, input logic [63:0] va, input logic [63:0] vb,
                          input logic vcin, input logic vsub,
                          output logic [63:0] esum, output logic ecout, output logic eovf);
    logic [63:0] mask;
    logic [63:0] be;
    logic [64:0] t;
    mask  = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    be    = (vsub ? ~vb : vb) & mask;
    t     = {1'b0, va & mask} + {1'b0, be} + {64'd0, vcin ^ vsub};
    esum  = t[63:0] & mask;
    ecout = t[n];
    eovf  = (va[n-1] == be[n-1]) && (esum[n-1] != va[n-1]);
  endtask

  // Offer one operand pair, scramble the inputs after acceptance, and count
  // the clock edges until out_valid rises.
  task automatic applyStimulus(input logic s8, input logic [63:0] va, input logic [63:0] vb,
                               input logic vcin, input logic vsub, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    sel8 = s8;
    a    = va;
    b    = vb;
    cin  = vcin;
    sub  = vsub;
    iv   = 1'b1;
    while (!rdy_m && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy_m) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    iv  = 1'b0;
    a   = ~va;
    b   = ~vb;
    cin = ~vcin;
    sub = ~vsub;
    lat = 0;
    while (!ov_m && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic popResult;
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
  endtask

  task automatic runCase(input string tag, input logic s8, input logic [63:0] va,
                         input logic [63:0] vb, input logic vcin, input logic vsub,
                         input logic [63:0] esum, input logic ecout, input logic eovf,
                         input int elat);
    int lat;
    applyStimulus(s8, va, vb, vcin, vsub, lat);
    checkOutput({tag, "_lat"},  64'(lat),     64'(elat));
    checkOutput({tag, "_sum"},  sum_m,        esum);
    checkOutput({tag, "_cout"}, 64'(cout_m),  64'(ecout));
    checkOutput({tag, "_ovf"},  64'(ovf_m),   64'(eovf));
    popResult();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat;
    int          saw;
    logic [63:0] ra, rb, es;
    logic        rc, rs, ec, eo;

    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b0;
    sel8 = 1'b0;
    a    = '0;
    b    = '0;
    cin  = 1'b0;
    sub  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  64'(rdy64), 64'd1);
    checkOutput("rst_out_valid", 64'(ov64),  64'd0);
    checkOutput("rst_sum",       sum64,      64'd0);
    checkOutput("rst_cout",      64'(cout64), 64'd0);
    checkOutput("rst_ovf",       64'(ovf64),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    runCase("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
            64'd0, 1'b1, 1'b0, 4);
    runCase("sub_neg", 1'b0, 64'd5, 64'd7, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4);
    runCase("sub_borrow", 1'b0, 64'd5, 64'd7, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 4);
    runCase("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1, 4);
    runCase("sub_ovf", 1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4);
    runCase("add_cin_carry", 1'b0, 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0,
            64'h0000_0000_0001_0000, 1'b0, 1'b0, 4);

    // Backpressure: result held while out_ready is low, second offer ignored.
    applyStimulus(1'b0, 64'd3, 64'd4, 1'b0, 1'b0, lat);
    checkOutput("bp_lat", 64'(lat), 64'd4);
    @(negedge clk);
    a   = 64'd10;
    b   = 64'd20;
    cin = 1'b0;
    sub = 1'b0;
    iv  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_sum",   sum64,        64'd7);
      checkOutput("bp_hold_valid", 64'(ov64),    64'd1);
      checkOutput("bp_hold_ready", 64'(rdy64),   64'd0);
      checkOutput("bp_hold_cout",  64'(cout64),  64'd0);
    end
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    checkOutput("bp_pop_valid", 64'(ov64),  64'd0);
    checkOutput("bp_pop_ready", 64'(rdy64), 64'd1);
    @(posedge clk);
    #1;
    iv = 1'b0;
    checkOutput("bp_second_accept", 64'(rdy64), 64'd0);
    lat = 0;
    while (!ov64 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp_second_lat", 64'(lat), 64'd4);
    checkOutput("bp_second_sum", sum64,    64'd30);
    popResult();

    // Reset while segment 2 is being processed aborts the operation.
    @(negedge clk);
    a   = 64'd1;
    b   = 64'd2;
    cin = 1'b0;
    sub = 1'b0;
    iv  = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_run_ready", 64'(rdy64), 64'd1);
    checkOutput("rst_run_valid", 64'(ov64),  64'd0);
    checkOutput("rst_run_sum",   sum64,      64'd0);
    saw = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ov64) saw++;
    end
    checkOutput("rst_run_no_valid", 64'(saw), 64'd0);

    // Single-segment instance.
    runCase("k1_ovf", 1'b1, 64'h80, 64'h80, 1'b0, 1'b0, 64'h00, 1'b1, 1'b1, 1);
    runCase("k1_sub", 1'b1, 64'h00, 64'h01, 1'b0, 1'b1, 64'hFF, 1'b0, 1'b0, 1);
    runCase("k1_add", 1'b1, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, 1);

    // Model-checked sweeps on both instances.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      refModel(64, ra, rb, rc, rs, es, ec, eo);
      runCase("rnd64", 1'b0, ra, rb, rc, rs, es, ec, eo, 4);
    end
    for (int i = 0; i < 6000; i++) begin
      ra = 64'($urandom_range(255));
      rb = 64'($urandom_range(255));
      rc = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      refModel(8, ra, rb, rc, rs, es, ec, eo);
      runCase("rnd8", 1'b1, ra, rb, rc, rs, es, ec, eo, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
